// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - RISC-V MEM stage: load/store FSM on a req/gnt/rvalid port, MEM-WB buffer, MEM forward
module mem_access_stage #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        lsu_enable_ip,
  input  logic [3:0]  lsu_operator_ip,
  input  logic [31:0] alu_result_ip,
  input  logic        alu_valid_ip,
  input  logic [31:0] mem_wdata_ip,
  input  logic [1:0]  wb_mux_ip,
  input  logic [4:0]  write_reg_addr_ip,
  input  logic [31:0] pc_addr_ip,
  input  logic [31:0] uimmd_ip,
  output logic        data_req_op,
  output logic [31:0] data_addr_op,
  output logic        data_we_op,
  output logic [3:0]  data_be_op,
  output logic [31:0] data_wdata_op,
  input  logic        data_gnt_ip,
  input  logic        data_rvalid_ip,
  input  logic [31:0] data_rdata_ip,
  output logic        stall_op,
  output logic [31:0] fw_mem_op,
  output logic        wb_valid_op,
  output logic [31:0] wb_data_op,
  output logic [4:0]  wb_reg_addr_op,
  output logic [1:0]  wb_mux_op,
  output logic [31:0] wb_pc_addr_op,
  output logic [31:0] wb_uimmd_op,
  output logic        mem_err_op
);
  // Operator encoding: bit 3 = store, bit 2 = unsigned load, bits 1:0 = log2(size).
  localparam logic [3:0] OP_LB = 4'h0, OP_LH = 4'h1, OP_LW = 4'h2, OP_LBU = 4'h4,
                         OP_LHU = 4'h5, OP_SB = 4'h8, OP_SH = 4'h9, OP_SW = 4'hA;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_RV} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  op_q, op_d, be_q, be_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, pc_q, pc_d, uimm_q, uimm_d;
  logic [4:0]  rd_q, rd_d;
  logic [1:0]  mux_q, mux_d;
  logic        wb_valid_q, wb_valid_d, err_q, err_d;
  logic [31:0] wb_data_q, wb_data_d, wb_pc_q, wb_pc_d, wb_uimm_q, wb_uimm_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [1:0]  wb_mux_q, wb_mux_d;

  logic        misaligned, mem_op, issue, retire_rv, abort;
  logic [3:0]  be_in;
  logic [31:0] wdata_in, load_data;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    be_in      = 4'b0000;
    wdata_in   = mem_wdata_ip;
    misaligned = 1'b0;
    case (lsu_operator_ip)
      OP_LB, OP_LBU: misaligned = 1'b0;
      OP_LH, OP_LHU: misaligned = alu_result_ip[0];
      OP_LW:         misaligned = |alu_result_ip[1:0];
      OP_SB: begin
        be_in    = 4'b0001 << alu_result_ip[1:0];
        wdata_in = {4{mem_wdata_ip[7:0]}};
      end
      OP_SH: begin
        misaligned = alu_result_ip[0];
        be_in      = alu_result_ip[1] ? 4'b1100 : 4'b0011;
        wdata_in   = {2{mem_wdata_ip[15:0]}};
      end
      OP_SW: begin
        misaligned = |alu_result_ip[1:0];
        be_in      = 4'b1111;
      end
      default: misaligned = 1'b0;
    endcase
  end

  assign mem_op    = reset && lsu_enable_ip && alu_valid_ip && (state_q == S_IDLE);
  assign issue     = mem_op && !misaligned;
  assign retire_rv = (state_q == S_WAIT_RV) && data_rvalid_ip;
  // A grant on the last allowed REQ cycle still moves to WAIT_RV; the abort then lands one cycle later.
  assign abort     = !retire_rv && (cnt_q >= CNT_LAST) &&
                     (((state_q == S_REQ) && !data_gnt_ip) || (state_q == S_WAIT_RV));
  assign stall_op  = issue || ((state_q != S_IDLE) && !retire_rv && !abort);
  assign fw_mem_op = alu_result_ip;

  always_comb begin
    data_req_op   = 1'b0;
    data_addr_op  = 32'h0;
    data_we_op    = 1'b0;
    data_be_op    = 4'b0000;
    data_wdata_op = 32'h0;
    if (issue) begin
      data_req_op   = 1'b1;
      data_addr_op  = {alu_result_ip[31:2], 2'b00};
      data_we_op    = lsu_operator_ip[3];
      data_be_op    = be_in;
      data_wdata_op = wdata_in;
    end else if (state_q == S_REQ) begin
      data_req_op   = 1'b1;
      data_addr_op  = {addr_q[31:2], 2'b00};
      data_we_op    = op_q[3];
      data_be_op    = be_q;
      data_wdata_op = wdata_q;
    end
  end

  always_comb begin
    rbyte = data_rdata_ip[{addr_q[1:0], 3'b000} +: 8];
    rhalf = addr_q[1] ? data_rdata_ip[31:16] : data_rdata_ip[15:0];
    case (op_q)
      OP_LB:   load_data = {{24{rbyte[7]}}, rbyte};
      OP_LBU:  load_data = {24'h0, rbyte};
      OP_LH:   load_data = {{16{rhalf[15]}}, rhalf};
      OP_LHU:  load_data = {16'h0, rhalf};
      default: load_data = data_rdata_ip;
    endcase
  end

  always_comb begin
    state_d = state_q;   cnt_d = cnt_q;     op_d = op_q;     be_d = be_q;
    addr_d = addr_q;     wdata_d = wdata_q; rd_d = rd_q;     mux_d = mux_q;
    pc_d = pc_q;         uimm_d = uimm_q;
    wb_valid_d = 1'b0;   err_d = 1'b0;      wb_data_d = wb_data_q;
    wb_rd_d = wb_rd_q;   wb_mux_d = wb_mux_q;
    wb_pc_d = wb_pc_q;   wb_uimm_d = wb_uimm_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = 8'd0;
        if (issue) begin
          op_d = lsu_operator_ip;  be_d = be_in;          addr_d = alu_result_ip;
          wdata_d = wdata_in;      rd_d = write_reg_addr_ip;
          mux_d = wb_mux_ip;       pc_d = pc_addr_ip;     uimm_d = uimmd_ip;
          state_d = data_gnt_ip ? S_WAIT_RV : S_REQ;
        end else begin
          wb_valid_d = mem_op ? 1'b1 : alu_valid_ip;
          err_d      = mem_op;
          wb_data_d  = alu_result_ip;
          wb_rd_d    = mem_op ? 5'd0 : write_reg_addr_ip;
          wb_mux_d   = wb_mux_ip;
          wb_pc_d    = pc_addr_ip;
          wb_uimm_d  = uimmd_ip;
        end
      end
      S_REQ, S_WAIT_RV: begin
        cnt_d = cnt_q + 8'd1;
        if (retire_rv || abort) begin
          state_d    = S_IDLE;
          wb_valid_d = 1'b1;
          err_d      = abort;
          wb_data_d  = abort ? addr_q : load_data;
          wb_rd_d    = (abort || op_q[3]) ? 5'd0 : rd_q;
          wb_mux_d   = mux_q;
          wb_pc_d    = pc_q;
          wb_uimm_d  = uimm_q;
        end else if ((state_q == S_REQ) && data_gnt_ip) begin
          state_d = S_WAIT_RV;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;  cnt_q <= 8'd0;    op_q <= 4'h0;     be_q <= 4'h0;
      addr_q <= 32'h0;    wdata_q <= 32'h0; rd_q <= 5'd0;     mux_q <= 2'd0;
      pc_q <= 32'h0;      uimm_q <= 32'h0;  wb_valid_q <= 1'b0; err_q <= 1'b0;
      wb_data_q <= 32'h0; wb_rd_q <= 5'd0;  wb_mux_q <= 2'd0;
      wb_pc_q <= 32'h0;   wb_uimm_q <= 32'h0;
    end else begin
      state_q <= state_d;     cnt_q <= cnt_d;     op_q <= op_d;       be_q <= be_d;
      addr_q <= addr_d;       wdata_q <= wdata_d; rd_q <= rd_d;       mux_q <= mux_d;
      pc_q <= pc_d;           uimm_q <= uimm_d;   wb_valid_q <= wb_valid_d;
      err_q <= err_d;         wb_data_q <= wb_data_d; wb_rd_q <= wb_rd_d;
      wb_mux_q <= wb_mux_d;   wb_pc_q <= wb_pc_d; wb_uimm_q <= wb_uimm_d;
    end
  end

  assign wb_valid_op    = wb_valid_q;
  assign wb_data_op     = wb_data_q;
  assign wb_reg_addr_op = wb_rd_q;
  assign wb_mux_op      = wb_mux_q;
  assign wb_pc_addr_op  = wb_pc_q;
  assign wb_uimmd_op    = wb_uimm_q;
  assign mem_err_op     = err_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - randomized bench for mem_access_stage against a transaction-level model
module tb_mem_access_stage;
  localparam int TO = 16;
  localparam logic [3:0] LB = 4'h0, LH = 4'h1, LW = 4'h2, LBU = 4'h4,
                         LHU = 4'h5, SB = 4'h8, SH = 4'h9, SW = 4'hA;
  localparam int NEVER = 99;

  logic        clock = 1'b0, reset = 1'b0;
  logic        lsu_enable_ip = 1'b0, alu_valid_ip = 1'b0;
  logic [3:0]  lsu_operator_ip = 4'h0;
  logic [31:0] alu_result_ip = 32'h0, mem_wdata_ip = 32'h0, pc_addr_ip = 32'h0, uimmd_ip = 32'h0;
  logic [1:0]  wb_mux_ip = 2'd0;
  logic [4:0]  write_reg_addr_ip = 5'd0;
  logic        data_gnt_ip = 1'b0, data_rvalid_ip = 1'b0;
  logic [31:0] data_rdata_ip = 32'h0;
  logic        data_req_op, data_we_op, stall_op, wb_valid_op, mem_err_op;
  logic [31:0] data_addr_op, data_wdata_op, fw_mem_op, wb_data_op, wb_pc_addr_op, wb_uimmd_op;
  logic [3:0]  data_be_op;
  logic [4:0]  wb_reg_addr_op;
  logic [1:0]  wb_mux_op;

  mem_access_stage #(.TIMEOUT_CYC(TO)) dut (
    .clock(clock), .reset(reset),
    .lsu_enable_ip(lsu_enable_ip), .lsu_operator_ip(lsu_operator_ip),
    .alu_result_ip(alu_result_ip), .alu_valid_ip(alu_valid_ip),
    .mem_wdata_ip(mem_wdata_ip), .wb_mux_ip(wb_mux_ip),
    .write_reg_addr_ip(write_reg_addr_ip), .pc_addr_ip(pc_addr_ip), .uimmd_ip(uimmd_ip),
    .data_req_op(data_req_op), .data_addr_op(data_addr_op), .data_we_op(data_we_op),
    .data_be_op(data_be_op), .data_wdata_op(data_wdata_op),
    .data_gnt_ip(data_gnt_ip), .data_rvalid_ip(data_rvalid_ip), .data_rdata_ip(data_rdata_ip),
    .stall_op(stall_op), .fw_mem_op(fw_mem_op),
    .wb_valid_op(wb_valid_op), .wb_data_op(wb_data_op), .wb_reg_addr_op(wb_reg_addr_op),
    .wb_mux_op(wb_mux_op), .wb_pc_addr_op(wb_pc_addr_op), .wb_uimmd_op(wb_uimmd_op),
    .mem_err_op(mem_err_op)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int op_bytes(input logic [3:0] op);
    case (op)
      LH, LHU, SH: return 2;
      LW, SW:      return 4;
      default:     return 1;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [3:0] op, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> ((a % 4) * 8)) & 32'hFF;
    h = (w >> (((a % 4) / 2) * 16)) & 32'hFFFF;
    case (op)
      LB:      return (b >= 128) ? b - 256 : b;
      LH:      return (h >= 32768) ? h - 65536 : h;
      LBU:     return b;
      LHU:     return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] ref_be(input logic [3:0] op, input logic [31:0] a);
    case (op)
      SB:      return 4'(1 << (a % 4));
      SH:      return ((a % 4) == 2) ? 4'hC : 4'h3;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [3:0] op, input logic [31:0] d);
    case (op)
      SB:      return (d & 32'hFF) * 32'h01010101;
      SH:      return (d & 32'hFFFF) * 32'h00010001;
      default: return d;
    endcase
  endfunction

  // Applies one EX-MEM entry starting just after a rising edge; g/r are grant delay and
  // rvalid delay after grant, in cycles. Returns just after the retiring edge.
  task automatic run_op(input logic en, input logic av, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] wd, input logic [4:0] rd, input int g, input int r,
                        input logic [31:0] rdata);
    logic [1:0]  mux;
    logic [31:0] pc, uimm;
    logic        is_mem, mis, store, aborted;
    int          end_c;
    mux = 2'($urandom); pc = $urandom; uimm = $urandom;
    lsu_enable_ip = en; alu_valid_ip = av; lsu_operator_ip = op; alu_result_ip = a;
    mem_wdata_ip = wd; write_reg_addr_ip = rd; wb_mux_ip = mux; pc_addr_ip = pc; uimmd_ip = uimm;
    data_rdata_ip = rdata; data_gnt_ip = 1'b0; data_rvalid_ip = 1'b0;
    is_mem = en && av;
    store  = (op == SB) || (op == SH) || (op == SW);
    mis    = (a % op_bytes(op)) != 0;
    if (!is_mem || mis) begin
      @(negedge clock);
      check("idle_req", data_req_op, 1'b0);
      check("idle_stall", stall_op, 1'b0);
      check("fw", fw_mem_op, a);
      @(posedge clock); #1;
      check("pass_valid", wb_valid_op, is_mem ? 1'b1 : av);
      check("pass_rd", wb_reg_addr_op, is_mem ? 5'd0 : rd);
      check("pass_err", mem_err_op, is_mem);
      check("pass_data", wb_data_op, a);
      check("pass_pc", wb_pc_addr_op, pc);
    end else begin
      aborted = !(g < TO && g + r <= TO);
      end_c   = aborted ? TO : g + r;
      for (int c = 0; c <= end_c; c++) begin
        if (c > 0) begin
          lsu_enable_ip = 1'($urandom); alu_valid_ip = 1'($urandom);
          lsu_operator_ip = 4'($urandom); alu_result_ip = $urandom; mem_wdata_ip = $urandom;
        end
        data_gnt_ip    = (c == g);
        data_rvalid_ip = (c == g + r);
        @(negedge clock);
        if (c == 0) check("fw", fw_mem_op, a);
        check("req", data_req_op, c <= g);
        if (c <= g) begin
          check("addr", data_addr_op, a & ~32'h3);
          check("we", data_we_op, store);
          check("be", data_be_op, store ? ref_be(op, a) : data_be_op);
          if (store) check("wdata", data_wdata_op, ref_wdata(op, wd));
        end
        check("stall", stall_op, c < end_c);
        @(posedge clock); #1;
        if (c < end_c) check("bubble", wb_valid_op, 1'b0);
      end
      data_gnt_ip = 1'b0; data_rvalid_ip = 1'b0;
      check("ret_valid", wb_valid_op, 1'b1);
      check("ret_err", mem_err_op, aborted);
      check("ret_rd", wb_reg_addr_op, (aborted || store) ? 5'd0 : rd);
      if (!aborted && !store) check("ret_data", wb_data_op, ref_load(op, a, rdata));
      check("ret_mux", wb_mux_op, mux);
      check("ret_uimm", wb_uimmd_op, uimm);
    end
  endtask

  task automatic idle_rvalid();
    lsu_enable_ip = 1'b0; alu_valid_ip = 1'b0; data_rvalid_ip = 1'b1;
    @(posedge clock); #1;
    data_rvalid_ip = 1'b0;
    check("stale_valid", wb_valid_op, 1'b0);
    check("stale_err", mem_err_op, 1'b0);
    check("stale_stall", stall_op, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clock);
    #1;
    check("rst_valid", wb_valid_op, 1'b0);
    check("rst_req", data_req_op, 1'b0);
    check("rst_stall", stall_op, 1'b0);
    check("rst_err", mem_err_op, 1'b0);
    check("rst_data", wb_data_op, 32'h0);
    reset = 1'b1;

    run_op(1, 1, LW,  32'h100, 32'h0,    5'd5, 0, 1, 32'hDEADBEEF);
    run_op(1, 1, LB,  32'h103, 32'h0,    5'd6, 0, 1, 32'h80FFFFFF);
    run_op(1, 1, LBU, 32'h103, 32'h0,    5'd7, 1, 2, 32'h80FFFFFF);
    run_op(1, 1, SH,  32'h202, 32'h1234, 5'd8, 0, 1, 32'h0);
    run_op(1, 1, LW,  32'h340, 32'h0,    5'd9, 3, 2, 32'hCAFEF00D);
    run_op(1, 1, LW,  32'h101, 32'h0,    5'd3, 0, 1, 32'h0);
    run_op(1, 1, LW,  32'h400, 32'h0,    5'd4, 0, 100, 32'h0);
    idle_rvalid();
    run_op(1, 1, SW,  32'h404, 32'h55AA, 5'd4, NEVER, 1, 32'h0);
    run_op(1, 1, LH,  32'h500, 32'h0,    5'd2, 3, 13, 32'h00008001);
    run_op(0, 1, LW,  32'h12345678, 32'h0, 5'd11, 0, 1, 32'h0);

    // Reset while waiting for rvalid.
    lsu_enable_ip = 1'b1; alu_valid_ip = 1'b1; lsu_operator_ip = LW;
    alu_result_ip = 32'h300; write_reg_addr_ip = 5'd12; data_gnt_ip = 1'b1;
    @(posedge clock); #1;
    data_gnt_ip = 1'b0;
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1; lsu_enable_ip = 1'b0; alu_valid_ip = 1'b0;
    #1;
    check("mid_rst_req", data_req_op, 1'b0);
    check("mid_rst_stall", stall_op, 1'b0);
    check("mid_rst_valid", wb_valid_op, 1'b0);
    check("mid_rst_rd", wb_reg_addr_op, 5'd0);
    check("mid_rst_pc", wb_pc_addr_op, 32'h0);
    idle_rvalid();
    run_op(1, 1, LW, 32'h304, 32'h0, 5'd13, 0, 1, 32'h01020304);

    for (int i = 0; i < 150; i++) begin
      logic [3:0]  ops [8];
      logic [31:0] a;
      int          k;
      ops = '{LB, LH, LW, LBU, LHU, SB, SH, SW};
      k = $urandom_range(0, 9);
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a = a & ~32'h3;
      run_op(k < 8, $urandom_range(0, 7) != 0, (k < 8) ? ops[k] : 4'($urandom), a, $urandom,
             5'($urandom), $urandom_range(0, 4), $urandom_range(1, 4), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
